// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 integer datapath.
// The ALU opcode values are the ones the decoder drives onto alu_control_op_i.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 4;
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [OP_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_NOR  = 4'b1100
    } alu_op_e;

    // SH_PASS keeps the shifter output defined while a non-shift op is selected.
    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/rv32_alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; the shift amount is already trimmed to log2(XLEN) bits.
module rv32_alu_shifter
    import rv32_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] shamt,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (mode)
            SH_SLL:  y = a << shamt;
            SH_SRL:  y = a >> shamt;
            SH_SRA:  y = $signed(a) >>> shamt;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/rv32_alu.sv
// RV32 integer ALU: combinational result/zero flag for the single-cycle path,
// plus a registered copy of both for later pipelining and debug.
module rv32_alu #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int OP_W = rv32_pkg::OP_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [OP_W-1:0] alu_control_op_i,
    input  logic [XLEN-1:0] a_num_i,
    input  logic [XLEN-1:0] b_num_i,
    output logic [XLEN-1:0] c_num_o,
    output logic            zero_o,
    output logic [XLEN-1:0] c_num_q_o,
    output logic            zero_q_o
);

    import rv32_pkg::*;

    localparam int AMT_W = $clog2(XLEN);

    alu_op_e         op;
    shift_mode_e     sh_mode;
    logic [XLEN-1:0] sh_result;
    logic            lt_signed;
    logic            lt_unsigned;

    assign op          = alu_op_e'(alu_control_op_i);
    assign lt_signed   = $signed(a_num_i) < $signed(b_num_i);
    assign lt_unsigned = a_num_i < b_num_i;

    always_comb begin
        sh_mode = SH_PASS;
        case (op)
            ALU_SLL: sh_mode = SH_SLL;
            ALU_SRL: sh_mode = SH_SRL;
            ALU_SRA: sh_mode = SH_SRA;
            default: sh_mode = SH_PASS;
        endcase
    end

    rv32_alu_shifter #(
        .WIDTH (XLEN),
        .AMT_W (AMT_W)
    ) u_shifter (
        .a     (a_num_i),
        .shamt (b_num_i[AMT_W-1:0]),
        .mode  (sh_mode),
        .y     (sh_result)
    );

    // Undefined opcodes fall through to zero, which also raises zero_o.
    always_comb begin
        c_num_o = '0;
        case (op)
            ALU_AND:  c_num_o = a_num_i & b_num_i;
            ALU_OR:   c_num_o = a_num_i | b_num_i;
            ALU_ADD:  c_num_o = a_num_i + b_num_i;
            ALU_XOR:  c_num_o = a_num_i ^ b_num_i;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  c_num_o = sh_result;
            ALU_SUB:  c_num_o = a_num_i - b_num_i;
            ALU_SLT:  c_num_o = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: c_num_o = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_NOR:  c_num_o = ~(a_num_i | b_num_i);
            default:  c_num_o = '0;
        endcase
    end

    assign zero_o = (c_num_o == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_num_q_o <= '0;
            zero_q_o  <= 1'b0;
        end else begin
            c_num_q_o <= c_num_o;
            zero_q_o  <= zero_o;
        end
    end

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: random sweeps against an arithmetic
// reference model, directed boundary cases, and the registered/reset path.
module tb_rv32_alu;

    logic        clk_i;
    logic        rst_ni;
    logic [3:0]  alu_control_op_i;
    logic [31:0] a_num_i;
    logic [31:0] b_num_i;
    logic [31:0] c_num_o;
    logic        zero_o;
    logic [31:0] c_num_q_o;
    logic        zero_q_o;

    int n_checks = 0;
    int n_pass   = 0;

    rv32_alu dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .alu_control_op_i (alu_control_op_i),
        .a_num_i          (a_num_i),
        .b_num_i          (b_num_i),
        .c_num_o          (c_num_o),
        .zero_o           (zero_o),
        .c_num_q_o        (c_num_q_o),
        .zero_q_o         (zero_q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: plain 64-bit integer arithmetic, shifts as multiply/divide by 2^n.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     ua;
        longint     ub;
        longint     sa;
        longint     sb;
        longint     pw;
        longint     q;
        logic [63:0] r64;
        int         sh;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        sh = b % 32;
        pw = 1;
        for (int i = 0; i < sh; i++) pw = pw * 2;
        r64 = '0;
        case (op)
            4'd0:  r64 = {32'b0, a & b};
            4'd1:  r64 = {32'b0, a | b};
            4'd2:  r64 = ua + ub;
            4'd3:  r64 = {32'b0, a ^ b};
            4'd4:  r64 = ua * pw;
            4'd5:  r64 = ua / pw;
            4'd6:  r64 = ua - ub;
            4'd7:  r64 = (sa < sb) ? 64'd1 : 64'd0;
            4'd8:  r64 = (ua < ub) ? 64'd1 : 64'd0;
            4'd9: begin
                q = sa / pw;
                if (sa < 0 && (sa % pw) != 0) q = q - 1;
                r64 = q;
            end
            4'd12: r64 = {32'b0, ~(a | b)};
            default: r64 = '0;
        endcase
        return r64[31:0];
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_control_op_i = op;
        a_num_i          = a;
        b_num_i          = b;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp;
        exp = ref_alu(alu_control_op_i, a_num_i, b_num_i);
        check32(tag, c_num_o, exp);
        check1({tag, "_zero"}, zero_o, exp == 32'h0);
    endtask

    logic [3:0] sweep_ops [4] = '{4'd0, 4'd1, 4'd2, 4'd6};
    logic [31:0] sh_a;

    initial begin
        rst_ni           = 1'b0;
        alu_control_op_i = 4'd0;
        a_num_i          = '0;
        b_num_i          = '0;
        #2;
        check32("reset_c_q", c_num_q_o, 32'h0);
        check1("reset_zero_q", zero_q_o, 1'b0);
        apply(4'd2, 32'd1, 32'd2);
        check32("comb_in_reset", c_num_o, 32'd3);
        @(posedge clk_i);
        #1;
        check32("held_in_reset", c_num_q_o, 32'h0);
        rst_ni = 1'b1;

        // Random sweep of the four core ops.
        foreach (sweep_ops[k]) begin
            for (int i = 0; i < 1000; i++) begin
                apply(sweep_ops[k], $urandom, $urandom);
                check_model($sformatf("sweep_op%0d", sweep_ops[k]));
                #1;
            end
        end

        // Random sweep across every opcode, including small/edge shift amounts.
        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < 60; i++) begin
                apply(4'(op), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
                check_model($sformatf("all_op%0d", op));
                #1;
            end
        end

        // Zero flag cases.
        apply(4'd6, 32'h1234_5678, 32'h1234_5678);
        check32("sub_eq", c_num_o, 32'h0);
        check1("sub_eq_zero", zero_o, 1'b1);
        apply(4'd2, 32'hFFFF_FFFF, 32'h1);
        check32("add_wrap", c_num_o, 32'h0);
        check1("add_wrap_zero", zero_o, 1'b1);
        apply(4'd1, 32'h0, 32'h1);
        check1("or_nonzero", zero_o, 1'b0);

        // Signed vs unsigned compare.
        apply(4'd7, 32'h8000_0000, 32'h1);
        check32("slt_neg", c_num_o, 32'h1);
        apply(4'd8, 32'h8000_0000, 32'h1);
        check32("sltu_big", c_num_o, 32'h0);
        apply(4'd7, 32'h8000_0000, 32'h0);
        check32("slt_neg_zero", c_num_o, 32'h1);

        // Shifts; upper bits of b must be ignored.
        sh_a = 32'h8000_00F0;
        apply(4'd4, sh_a, 32'h24);
        check32("sll4", c_num_o, 32'h0000_0F00);
        apply(4'd5, sh_a, 32'h24);
        check32("srl4", c_num_o, 32'h0800_000F);
        apply(4'd9, sh_a, 32'h24);
        check32("sra4", c_num_o, 32'hF800_000F);
        apply(4'd4, sh_a, 32'h0);
        check32("sll0", c_num_o, sh_a);
        apply(4'd5, sh_a, 32'h0);
        check32("srl0", c_num_o, sh_a);
        apply(4'd9, sh_a, 32'h0);
        check32("sra0", c_num_o, sh_a);
        apply(4'd9, 32'h8000_0001, 32'd31);
        check32("sra31", c_num_o, 32'hFFFF_FFFF);

        // Undefined opcode and NOR.
        apply(4'b1111, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        check32("undef_c", c_num_o, 32'h0);
        check1("undef_zero", zero_o, 1'b1);
        apply(4'b1100, 32'h0, 32'h0);
        check32("nor0", c_num_o, 32'hFFFF_FFFF);
        check1("nor0_zero", zero_o, 1'b0);

        // Registered path: load a value, then reset asynchronously between edges.
        @(negedge clk_i);
        apply(4'd3, 32'hA5A5_0000, 32'h0000_5A5A);
        @(posedge clk_i);
        #1;
        check32("q_load", c_num_q_o, 32'hA5A5_5A5A);
        check1("q_load_zero", zero_q_o, 1'b0);
        #1;
        rst_ni = 1'b0;
        #1;
        check32("q_async_rst", c_num_q_o, 32'h0);
        check1("q_async_rst_zero", zero_q_o, 1'b0);
        rst_ni = 1'b1;
        apply(4'd2, 32'd5, 32'd7);
        check32("add_comb", c_num_o, 32'd12);
        check32("q_before_edge", c_num_q_o, 32'h0);
        @(posedge clk_i);
        #1;
        check32("q_after_edge", c_num_q_o, 32'd12);
        check1("q_after_edge_zero", zero_q_o, 1'b0);
        apply(4'b1010, 32'd5, 32'd7);
        @(posedge clk_i);
        #1;
        check32("q_undef", c_num_q_o, 32'h0);
        check1("q_undef_zero", zero_q_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- 32-bit integer ALU for the RV32 single-cycle datapath. It sits between the register file/immediate mux and the writeback/branch logic.
- Result and zero flag are combinational, so they are usable within the same cycle.
- A registered copy of result and flag is also provided, with one-cycle latency, for later pipelining and debug.

Parameters:
- XLEN, 32, operand and result width.
- OP_W, 4, width of the control opcode.

Ports:
- clk_i  input  1  clock; rising edge updates the registered outputs only.
- rst_ni  input  1  asynchronous active-low reset.
- alu_control_op_i  input  4  operation select (encoding below).
- a_num_i  input  32  operand A.
- b_num_i  input  32  operand B (also the shift amount source).
- c_num_o  output  32  combinational result.
- zero_o  output  1  combinational flag; 1 when c_num_o == 0.
- c_num_q_o  output  32  c_num_o registered on the rising edge of clk_i.
- zero_q_o  output  1  zero_o registered on the rising edge of clk_i.

Behaviour:
- Opcode encoding:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b, modulo 2^32, carry discarded
  - 0011 XOR: a ^ b
  - 0100 SLL: a << b[4:0]
  - 0101 SRL: a >> b[4:0], logical
  - 0110 SUB: a - b, modulo 2^32, borrow discarded
  - 0111 SLT: {31'b0, signed(a) < signed(b)}
  - 1000 SLTU: {31'b0, a < b unsigned}
  - 1001 SRA: a >>> b[4:0], arithmetic (sign-filled)
  - 1100 NOR: ~(a | b)
  - All other codes (1010, 1011, 1101, 1110, 1111): result 32'h0000_0000.
- Shift operations use only b[4:0]; b[31:5] is ignored.
- No overflow or exception signalling. Signed overflow on ADD/SUB wraps silently.
- c_num_o and zero_o are purely combinational:
  - zero latency from any input change;
  - no latches; a default assignment is required.
- zero_o is derived from the final c_num_o, including the 0 result for undefined opcodes, so zero_o = 1 for those codes.
- Registered path:
  - on posedge clk_i, c_num_q_o <= c_num_o and zero_q_o <= zero_o;
  - on negedge rst_ni, both clear immediately: c_num_q_o = 0, zero_q_o = 0.
- Reset:
  - reset has no effect on the combinational outputs, which are valid during reset;
  - reset deasserting mid-operation: the registered outputs load on the first rising edge after deassertion.
- Boundary cases:
  - SUB with a == b gives 0 and zero_o = 1.
  - ADD 32'hFFFF_FFFF + 1 gives 0 and zero_o = 1.
  - SLT 32'h8000_0000 vs 0 gives 1.
  - SLTU of the same operands gives 0.
  - Shift amount 0 returns a unchanged.
  - SRA of a negative value by 31 gives 32'hFFFF_FFFF.

Decomposition:
- Shared package rv32_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the encodings above (ALU_AND … ALU_NOR);
  - constant XLEN = 32.
- One sub-module is natural: rv32_alu_shifter, which handles SLL/SRL/SRA from a[31:0], b[4:0] and a 2-bit mode.
- Everything else is a single always_comb case statement plus one always_ff for the registered outputs.

Test Plan:
1. Random sweep: 1000 random a/b pairs for each of AND, OR, ADD, SUB. c_num_o must equal a&b, a|b, a+b, a-b respectively, checked 1 time unit after the inputs settle. zero_o must equal (c_num_o == 0).
2. Zero flag:
   - SUB with a = b = 32'h1234_5678 → c_num_o = 0, zero_o = 1.
   - ADD 32'hFFFF_FFFF + 32'h1 → c_num_o = 0, zero_o = 1.
   - OR with a = 0, b = 1 → zero_o = 0.
3. Compare operations with a = 32'h8000_0000, b = 32'h0000_0001:
   - SLT → 1;
   - SLTU → 0.
4. Shifts with a = 32'h8000_00F0:
   - b = 32'h0000_0024 (amount 4): SLL → 32'h0000_0F00, SRL → 32'h0800_000F, SRA → 32'hF800_000F;
   - b = 0: all three shifts → a unchanged.
5. Undefined opcode 4'b1111 with arbitrary operands → c_num_o = 0, zero_o = 1. NOR with a = b = 0 → 32'hFFFF_FFFF.
6. Registered path:
   - assert rst_ni = 0 asynchronously between edges → c_num_q_o and zero_q_o read 0 immediately;
   - release reset, apply ADD 5 + 7 → c_num_q_o = 12 after the next rising edge, not before.
